// File: rtl/snax_csr_router_pkg.sv
// Shared definitions for the SNAX CSR router: CSR op encodings, the
// default SNAX request/response structs and the tracking-FIFO entry.
package snax_csr_router_pkg;

   localparam int unsigned IdWidth        = 5;
   localparam logic [31:0] CsrBaseDefault = 32'h0000_03c0;

   // data_op carries the RISC-V instruction; funct3 + opcode identify the CSR op
   localparam logic [31:0] CsrOpMask = 32'h0000_707f;
   localparam logic [31:0] OpCsrrw   = 32'h0000_1073;
   localparam logic [31:0] OpCsrrs   = 32'h0000_2073;
   localparam logic [31:0] OpCsrrc   = 32'h0000_3073;
   localparam logic [31:0] OpCsrrsi  = 32'h0000_6073;
   localparam logic [31:0] OpCsrrci  = 32'h0000_7073;

   typedef struct packed {
      logic [31:0]        data_op;
      logic [31:0]        data_arga;
      logic [31:0]        data_argb;
      logic [IdWidth-1:0] id;
   } snax_acc_req_t;

   typedef struct packed {
      logic [31:0]        data;
      logic [IdWidth-1:0] id;
      logic               error;
   } snax_acc_rsp_t;

   // One outstanding request: who asked, which channel, and whether it missed
   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [2:0]         ch;
      logic               err;
   } track_entry_t;

   // Set/clear ops only read-modify the CSR bits; everything else writes
   function automatic logic csr_is_write(input logic [31:0] op);
      logic [31:0] masked;
      masked = op & CsrOpMask;
      return !((masked == OpCsrrs) || (masked == OpCsrrsi) ||
               (masked == OpCsrrc) || (masked == OpCsrrci));
   endfunction

endpackage

// File: rtl/snax_csr_router_if.sv
// SNAX accelerator request/response channel bundle.
interface snax_csr_router_if #(
   parameter type acc_req_t = snax_csr_router_pkg::snax_acc_req_t,
   parameter type acc_rsp_t = snax_csr_router_pkg::snax_acc_rsp_t
);
   logic     qvalid;
   logic     qready;
   acc_req_t req;
   logic     pvalid;
   logic     pready;
   acc_rsp_t resp;

   modport master (output qvalid, req, pready, input qready, pvalid, resp);
   modport slave  (input qvalid, req, pready, output qready, pvalid, resp);
endinterface

// File: rtl/snax_csr_id_fifo.sv
// In-order tracking FIFO for outstanding CSR requests.
module snax_csr_id_fifo #(
   parameter int unsigned Width = 9,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_r [Depth];
   logic [PtrW-1:0]  wptr_r;
   logic [PtrW-1:0]  rptr_r;
   logic [CntW-1:0]  count_r;
   logic             push_s;
   logic             pop_s;

   assign full_o  = (count_r == CntW'(Depth));
   assign empty_o = (count_r == CntW'(0));
   assign push_s  = push_i && !full_o;
   assign pop_s   = pop_i && !empty_o;
   assign data_o  = mem_r[rptr_r];

   // Pointers wrap naturally (Depth is a power of two); count tracks occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) wptr_r <= wptr_r + PtrW'(1);
         if (pop_s)  rptr_r <= rptr_r + PtrW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CntW'(1);
            2'b01:   count_r <= count_r - CntW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care while empty so no reset needed
   always_ff @(posedge clk_i) begin
      if (push_s) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/snax_csr_router.sv
// Routes SNAX CSR accesses to per-accelerator CSR channels by address window
// and returns responses in acceptance order through one output register.
module snax_csr_router
   import snax_csr_router_pkg::*;
#(
   parameter int unsigned NumChannels    = 2,
   parameter logic [31:0] CsrBase        = CsrBaseDefault,
   parameter int unsigned CsrsPerChannel = 16,
   parameter int unsigned IdFifoDepth    = 4,
   parameter type         acc_req_t      = snax_acc_req_t,
   parameter type         acc_rsp_t      = snax_acc_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   snax_csr_router_if.slave       snax,
   output logic [31:0]            csr_req_data_o [NumChannels],
   output logic [31:0]            csr_req_addr_o [NumChannels],
   output logic [NumChannels-1:0] csr_req_write_o,
   output logic [NumChannels-1:0] csr_req_valid_o,
   input  logic [NumChannels-1:0] csr_req_ready_i,
   input  logic [NumChannels-1:0] csr_rsp_valid_i,
   input  logic [31:0]            csr_rsp_data_i [NumChannels],
   output logic [NumChannels-1:0] csr_rsp_ready_o
);
   localparam int unsigned ChShift    = $clog2(CsrsPerChannel);
   localparam logic [31:0] LocalMask  = 32'(CsrsPerChannel - 1);
   localparam int unsigned EntryWidth = $bits(track_entry_t);

   acc_req_t               req_s;
   acc_rsp_t               resp_r;
   logic                   pvalid_r;
   logic [31:0]            off_s;
   logic [31:0]            ch_wide_s;
   logic [2:0]             ch_s;
   logic                   in_range_s;
   logic                   write_s;
   logic                   sel_ready_s;
   logic                   qready_s;
   logic                   accept_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   track_entry_t           push_entry_s;
   logic [EntryWidth-1:0]  head_raw_s;
   track_entry_t           head_s;
   logic                   out_free_s;
   logic                   head_valid_s;
   logic [31:0]            head_data_s;
   logic                   load_s;

   assign req_s = snax.req;

   // Address decode: window offset, target channel and range check
   always_comb begin
      off_s      = req_s.data_argb - CsrBase;
      ch_wide_s  = off_s >> ChShift;
      in_range_s = (req_s.data_argb >= CsrBase) && (ch_wide_s < 32'(NumChannels));
      ch_s       = ch_wide_s[2:0];
      write_s    = csr_is_write(req_s.data_op);
   end

   // Fan the request out; only the decoded channel sees valid
   always_comb begin
      sel_ready_s = 1'b0;
      for (int i = 0; i < NumChannels; i++) begin
         csr_req_data_o[i]  = req_s.data_arga;
         csr_req_addr_o[i]  = off_s & LocalMask;
         csr_req_write_o[i] = write_s;
         if (in_range_s && (ch_s == 3'(i))) begin
            csr_req_valid_o[i] = snax.qvalid && !fifo_full_s;
            sel_ready_s        = csr_req_ready_i[i];
         end else begin
            csr_req_valid_o[i] = 1'b0;
         end
      end
      // qready must not depend on qvalid; misses are absorbed locally
      qready_s = !fifo_full_s && (!in_range_s || sel_ready_s);
   end

   assign snax.qready  = qready_s;
   assign accept_s     = snax.qvalid && qready_s;
   assign push_entry_s = '{id: req_s.id, ch: ch_s, err: !in_range_s};

   snax_csr_id_fifo #(
      .Width (EntryWidth),
      .Depth (IdFifoDepth)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept_s),
      .data_i  (push_entry_s),
      .pop_i   (load_s),
      .data_o  (head_raw_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign head_s     = track_entry_t'(head_raw_s);
   assign out_free_s = !pvalid_r || snax.pready;

   // Only the channel owning the head entry may hand over its response
   always_comb begin
      head_valid_s = 1'b0;
      head_data_s  = 32'h0000_0000;
      for (int i = 0; i < NumChannels; i++) begin
         csr_rsp_ready_o[i] = 1'b0;
         if (head_s.ch == 3'(i)) begin
            head_valid_s = csr_rsp_valid_i[i];
            head_data_s  = csr_rsp_data_i[i];
            if (!fifo_empty_s && !head_s.err) begin
               csr_rsp_ready_o[i] = out_free_s;
            end else begin
               csr_rsp_ready_o[i] = 1'b0;
            end
         end
      end
      if (fifo_empty_s) begin
         load_s = 1'b0;
      end else if (head_s.err) begin
         load_s = out_free_s;
      end else begin
         load_s = out_free_s && head_valid_s;
      end
   end

   // Response output register; payload held until the core takes it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pvalid_r <= 1'b0;
         resp_r   <= '0;
      end else if (load_s) begin
         pvalid_r     <= 1'b1;
         resp_r.data  <= head_s.err ? 32'h0000_0000 : head_data_s;
         resp_r.id    <= head_s.id;
         resp_r.error <= head_s.err;
      end else if (snax.pready) begin
         pvalid_r <= 1'b0;
      end else begin
         pvalid_r <= pvalid_r;
      end
   end

   assign snax.pvalid = pvalid_r;
   assign snax.resp   = resp_r;

endmodule
